// File: rtl/host_line_writer.sv
// host_line_writer
//   Feeds host pixel words into the display's ping-pong line buffers (Buf0/Buf1).
//   - Host words arrive over HostValid/HostReady and are steered into the buffer
//     currently selected for writing.
//   - Write data, address and enables are registered (one cycle after the transfer).
//   - A buffer is flagged full with its last write. It stays full until the display
//     controller pulses its release.
//   - HostSOF restarts the current line at address 0 and clears the line counter.
//
// Optional feature macro: WR_STATS_EN
//   - Defined:   StallCnt is a saturating count of cycles with HostValid=1 and
//                HostReady=0. It is cleared by reset and by an SOF transfer.
//   - Undefined: StallCnt is tied to zero.
//
// FSM states
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_FILL | accepting host words into the selected buffer while it is not full
//   ST_WAIT | both buffers full after a line completed; hold the host off until
//           | the selected buffer is released, then resume one cycle later

module host_line_writer #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 20,
    parameter int WORDS_PER_BUF = 640
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] HostData,
    input  logic              HostValid,
    input  logic              HostSOF,
    output logic              HostReady,
    output logic [DATA_W-1:0] WData,
    output logic [ADDR_W-1:0] WAddr,
    output logic              WE0,
    output logic              WE1,
    output logic              Buf0Full,
    output logic              Buf1Full,
    input  logic              Buf0Release,
    input  logic              Buf1Release,
    output logic [15:0]       LineCnt,
    output logic [15:0]       StallCnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_BUF - 1);

    // Reject parameter sets the address counter cannot represent.
    if (WORDS_PER_BUF < 2 || longint'(WORDS_PER_BUF) > (longint'(1) << ADDR_W)) begin : g_bad_param
        $error("host_line_writer: WORDS_PER_BUF out of range for ADDR_W");
    end

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          full_q, full_d;
    logic [15:0]         line_cnt_q, line_cnt_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [1:0]          we_q, we_d;

    logic                full_sel;
    logic                full_oth;
    logic                host_ready;
    logic                xfer;
    logic                sof_xfer;
    logic                line_done;

    // Handshake qualifiers.
    // - Ready depends only on state, the full flags and reset, never on HostValid.
    // - Reset gates Ready so it drops at once when reset is asserted.
    always_comb begin
        full_sel   = wr_sel_q ? full_q[1] : full_q[0];
        full_oth   = wr_sel_q ? full_q[0] : full_q[1];
        host_ready = ~reset & (state_q == ST_FILL) & ~full_sel;
        xfer       = HostValid & host_ready;
        sof_xfer   = xfer & HostSOF;
        line_done  = xfer & ~HostSOF & (addr_q == LAST_ADDR);
    end

    // Next-state logic for the write path, the full flags and the FSM.
    always_comb begin
        state_d    = state_q;
        wr_sel_d   = wr_sel_q;
        addr_d     = addr_q;
        full_d     = full_q;
        line_cnt_d = line_cnt_q;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        we_d       = 2'b00;

        // Releases are applied first so that a coincident set of the same buffer wins.
        if (Buf0Release) begin
            full_d[0] = 1'b0;
        end
        if (Buf1Release) begin
            full_d[1] = 1'b0;
        end

        if (xfer) begin
            wdata_d = HostData;
            we_d    = wr_sel_q ? 2'b10 : 2'b01;
        end

        if (sof_xfer) begin
            // Restart the line in the current buffer; any partial content is abandoned.
            waddr_d    = '0;
            addr_d     = ADDR_W'(1);
            line_cnt_d = 16'h0000;
        end else if (xfer) begin
            waddr_d = addr_q;
            if (line_done) begin
                full_d[wr_sel_q] = 1'b1;
                addr_d           = '0;
                wr_sel_d         = ~wr_sel_q;
                line_cnt_d       = line_cnt_q + 16'd1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        unique case (state_q)
            ST_FILL: begin
                if (line_done && full_oth) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!full_sel) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // State and output registers; everything returns to zero on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FILL;
            wr_sel_q   <= 1'b0;
            addr_q     <= '0;
            full_q     <= 2'b00;
            line_cnt_q <= 16'h0000;
            wdata_q    <= '0;
            waddr_q    <= '0;
            we_q       <= 2'b00;
        end else begin
            state_q    <= state_d;
            wr_sel_q   <= wr_sel_d;
            addr_q     <= addr_d;
            full_q     <= full_d;
            line_cnt_q <= line_cnt_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            we_q       <= we_d;
        end
    end

`ifdef WR_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating stall counter; an SOF transfer starts a fresh measurement.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (sof_xfer) begin
            stall_cnt_d = 16'h0000;
        end else if (HostValid && !host_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
`else
    assign StallCnt = 16'h0000;
`endif

    assign HostReady = host_ready;
    assign WData     = wdata_q;
    assign WAddr     = waddr_q;
    assign WE0       = we_q[0];
    assign WE1       = we_q[1];
    assign Buf0Full  = full_q[0];
    assign Buf1Full  = full_q[1];
    assign LineCnt   = line_cnt_q;

endmodule
